// File: rtl/cpu_run_controller_pkg.sv
// cpu_run_pkg: shared state encoding, v0 width and counter width helper for the run controller.
// Optional macro CPU_RUN_FINISH_CYCLE_EN is consumed by the interface, channel and top files.
package cpu_run_pkg;
  typedef enum logic [2:0] {IDLE, RESET, CHECK, RUN, DONE, TIMEOUT} run_state_t;
  localparam int V0_W = 32;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/cpu_run_controller_if.sv
// cpu_run_controller_if: harness-side bundle between the test harness and the run controller.
// Macro CPU_RUN_FINISH_CYCLE_EN adds the packed finish_cycle output.
interface cpu_run_controller_if import cpu_run_pkg::*; #(
  parameter int NUM_CPU = 1,
  parameter int CNT_W = 14
);
  logic start;
  logic [NUM_CPU-1:0] cpu_active;
  logic [V0_W*NUM_CPU-1:0] cpu_register_v0;
  logic cpu_reset;
  logic busy;
  logic done;
  logic timeout;
  logic error;
  logic [NUM_CPU-1:0] error_mask;
  logic [NUM_CPU-1:0] finished_mask;
  logic [V0_W*NUM_CPU-1:0] result_v0;
  logic [CNT_W-1:0] cycle_count;
`ifdef CPU_RUN_FINISH_CYCLE_EN
  logic [CNT_W*NUM_CPU-1:0] finish_cycle;
`endif
  modport master (
`ifdef CPU_RUN_FINISH_CYCLE_EN
    input finish_cycle,
`endif
    output start, cpu_active, cpu_register_v0,
    input cpu_reset, busy, done, timeout, error, error_mask, finished_mask, result_v0, cycle_count
  );
  modport slave (
`ifdef CPU_RUN_FINISH_CYCLE_EN
    output finish_cycle,
`endif
    input start, cpu_active, cpu_register_v0,
    output cpu_reset, busy, done, timeout, error, error_mask, finished_mask, result_v0, cycle_count
  );
endinterface

// File: rtl/cpu_run_controller_channel.sv
// cpu_run_channel: per-CPU finish detector, error flag and v0 capture.
// Macro CPU_RUN_FINISH_CYCLE_EN adds the finish_cycle capture register.
module cpu_run_channel import cpu_run_pkg::*; #(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic             check,
  input  logic             run,
  input  logic             active,
  input  logic [V0_W-1:0]  v0,
`ifdef CPU_RUN_FINISH_CYCLE_EN
  input  logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] finish_cycle,
`endif
  output logic             finished_next,
  output logic             finished,
  output logic             error,
  output logic [V0_W-1:0]  result
);
  logic prev_q, prev_d, fin_q, fin_d, err_q, err_d, hit;
  logic [V0_W-1:0] res_q, res_d;
`ifdef CPU_RUN_FINISH_CYCLE_EN
  logic [CNT_W-1:0] fc_q, fc_d;
`endif
  // a CHECK-time miss and a RUN-time falling edge both count as a finish
  always_comb begin
    hit = check ? !active : (run && !fin_q && prev_q && !active);
    prev_d = arm ? 1'b0 : (check || (run && !fin_q)) ? active : prev_q;
    fin_d = arm ? 1'b0 : (fin_q | hit);
    err_d = arm ? 1'b0 : (err_q | (check & !active));
    res_d = arm ? '0 : hit ? v0 : res_q;
`ifdef CPU_RUN_FINISH_CYCLE_EN
    fc_d = arm ? '0 : (hit && run) ? cnt : fc_q;
`endif
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b0;
      fin_q <= 1'b0;
      err_q <= 1'b0;
      res_q <= '0;
`ifdef CPU_RUN_FINISH_CYCLE_EN
      fc_q <= '0;
`endif
    end else begin
      prev_q <= prev_d;
      fin_q <= fin_d;
      err_q <= err_d;
      res_q <= res_d;
`ifdef CPU_RUN_FINISH_CYCLE_EN
      fc_q <= fc_d;
`endif
    end
  end
  assign finished_next = fin_d;
  assign finished = fin_q;
  assign error = err_q;
  assign result = res_q;
`ifdef CPU_RUN_FINISH_CYCLE_EN
  assign finish_cycle = fc_q;
`endif
endmodule

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: CPU reset sequencer, active-check, finish/timeout monitor for NUM_CPU cores.
// Macro CPU_RUN_FINISH_CYCLE_EN adds per-channel finish_cycle capture.
module cpu_run_controller import cpu_run_pkg::*; #(
  parameter int NUM_CPU = 1,
  parameter int RESET_CYCLES = 1,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int CNT_W = cnt_width(TIMEOUT_CYCLES)
) (
  input logic clk,
  input logic reset,
  cpu_run_controller_if.slave bus
);
  localparam int RC_W = cnt_width(RESET_CYCLES);
  run_state_t state_q, state_d;
  logic [RC_W-1:0] rcnt_q, rcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic cpu_reset_q, cpu_reset_d, busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
  logic arm, check, run, all_fin;
  logic [NUM_CPU-1:0] fin_next, fin_w, err_w;
  logic [V0_W*NUM_CPU-1:0] res_w;
  always_comb begin
    arm = bus.start & !busy_q;
    check = state_q == CHECK;
    run = state_q == RUN;
    all_fin = &fin_next;
    state_d = state_q;
    rcnt_d = rcnt_q;
    cnt_d = cnt_q;
    cpu_reset_d = cpu_reset_q;
    done_d = done_q;
    timeout_d = timeout_q;
    if (arm) begin
      state_d = RESET;
      rcnt_d = '0;
      cnt_d = '0;
      cpu_reset_d = 1'b1;
      done_d = 1'b0;
      timeout_d = 1'b0;
    end else if (state_q == RESET) begin
      rcnt_d = rcnt_q + 1'b1;
      if (rcnt_q == RC_W'(RESET_CYCLES - 1)) begin
        state_d = CHECK;
        cpu_reset_d = 1'b0;
      end
    end else if (check) begin
      state_d = all_fin ? DONE : RUN;
      done_d = all_fin;
    end else if (run) begin
      cnt_d = (cnt_q == CNT_W'(TIMEOUT_CYCLES)) ? cnt_q : cnt_q + 1'b1;
      // a finish landing on the timeout cycle takes priority
      if (all_fin) begin
        state_d = DONE;
        done_d = 1'b1;
      end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = TIMEOUT;
        timeout_d = 1'b1;
      end
    end
    busy_d = state_d inside {RESET, CHECK, RUN};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rcnt_q <= '0;
      cnt_q <= '0;
      cpu_reset_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q <= rcnt_d;
      cnt_q <= cnt_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q <= busy_d;
      done_q <= done_d;
      timeout_q <= timeout_d;
    end
  end
  for (genvar i = 0; i < NUM_CPU; i++) begin : g_ch
    cpu_run_channel #(.CNT_W(CNT_W)) u_ch (
      .clk(clk),
      .reset(reset),
      .arm(arm),
      .check(check),
      .run(run),
      .active(bus.cpu_active[i]),
      .v0(bus.cpu_register_v0[V0_W*i +: V0_W]),
`ifdef CPU_RUN_FINISH_CYCLE_EN
      .cnt(cnt_d),
      .finish_cycle(bus.finish_cycle[CNT_W*i +: CNT_W]),
`endif
      .finished_next(fin_next[i]),
      .finished(fin_w[i]),
      .error(err_w[i]),
      .result(res_w[V0_W*i +: V0_W])
    );
  end
  assign bus.cpu_reset = cpu_reset_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.timeout = timeout_q;
  assign bus.error = |err_w;
  assign bus.error_mask = err_w;
  assign bus.finished_mask = fin_w;
  assign bus.result_v0 = res_w;
  assign bus.cycle_count = cnt_q;
endmodule
